// File: rtl/alu_result_stage_if.sv
// Handshake and payload bundle between the ALU units, the result stage and writeback.
interface alu_result_stage_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    sel;
  logic [DW-1:0] logres;
  logic [DW-1:0] arithres;
  logic          arith_c;
  logic          arith_v;
  logic [DW-1:0] shiftres;
  logic [DW-1:0] opb;
  logic [RW-1:0] rd;
  logic          we;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic [RW-1:0] out_rd;
  logic          out_we;
  logic [3:0]    out_flags;

  // Driver of instructions and consumer of results (execute + writeback side).
  modport master (
    output in_valid, sel, logres, arithres, arith_c, arith_v, shiftres, opb, rd, we,
    input  in_ready,
    input  out_valid, out_result, out_rd, out_we, out_flags,
    output out_ready
  );

  // The result stage itself.
  modport slave (
    input  in_valid, sel, logres, arithres, arith_c, arith_v, shiftres, opb, rd, we,
    output in_ready,
    output out_valid, out_result, out_rd, out_we, out_flags,
    input  out_ready
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result select + NZCV flag generation behind a 2-entry skid buffer.
// Optional: define ALU_RETIRE_CNT_EN to add the retire_cnt output, which counts
// releases that carry a register write.
module alu_result_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_result_stage_if.slave   bus
`ifdef ALU_RETIRE_CNT_EN
  ,
  output logic [31:0]         retire_cnt
`endif
);

  typedef struct packed {
    logic [DW-1:0] result;
    logic [RW-1:0] rd;
    logic          we;
    logic [3:0]    flags;
  } entry_t;

  // state[0] = main valid, state[1] = skid valid
  localparam logic [1:0] S_EMPTY = 2'b00;
  localparam logic [1:0] S_ONE   = 2'b01;
  localparam logic [1:0] S_FULL  = 2'b11;

  logic [1:0]    state_q, state_d;
  entry_t        main_q, skid_q, in_entry;
  logic [DW-1:0] sel_res;
  logic          accept, rel;
  logic          load_main_in, load_main_skid, load_skid, drop_main;

  assign bus.in_ready   = rst_n & ~state_q[1];
  assign bus.out_valid  = state_q[0];
  assign bus.out_result = main_q.result;
  assign bus.out_rd     = main_q.rd;
  assign bus.out_we     = main_q.we;
  assign bus.out_flags  = main_q.flags;

  assign accept = bus.in_valid & bus.in_ready;
  assign rel    = bus.out_valid & bus.out_ready;

  // Pick the unit result and derive {N,Z,C,V}; C/V only mean something for arithmetic.
  always_comb begin
    sel_res = bus.logres;
    case (bus.sel)
      2'b00:   sel_res = bus.logres;
      2'b01:   sel_res = bus.arithres;
      2'b10:   sel_res = bus.shiftres;
      default: sel_res = bus.opb;
    endcase
    in_entry.result = sel_res;
    in_entry.rd     = bus.rd;
    in_entry.we     = bus.we;
    in_entry.flags  = {sel_res[DW-1],
                       (sel_res == '0),
                       (bus.sel == 2'b01) & bus.arith_c,
                       (bus.sel == 2'b01) & bus.arith_v};
  end

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_EMPTY;
    else        state_q <= state_d;
  end

  // Next occupancy and the register load controls it implies.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    drop_main      = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          state_d      = S_ONE;
          load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (accept && rel) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_d   = S_FULL;
          load_skid = 1'b1;
        end else if (rel) begin
          state_d   = S_EMPTY;
          drop_main = 1'b1;
        end
      end
      S_FULL: begin
        if (rel) begin
          state_d        = S_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Main and skid payload registers; a drained main keeps out_we low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q    <= in_entry;
      else if (load_main_skid) main_q    <= skid_q;
      else if (drop_main)      main_q.we <= 1'b0;

      if (load_skid)           skid_q <= in_entry;
      else if (load_main_skid) skid_q <= '0;
    end
  end

`ifdef ALU_RETIRE_CNT_EN
  // Count retired instructions that write the register file; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               retire_cnt <= '0;
    else if (rel && main_q.we) retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule
